// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter and the divider family:
// FSM state encoding and an elaboration-time ceil(log2) helper.
package pulse_period_meter_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // ceil(log2(v)); returns 0 for v <= 1. Usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector for a clk-synchronous pulse train.
// The history register runs every cycle so an edge is never missed on re-arm.
module pulse_period_meter_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic rise_o
);

  logic pulse_q;

  // Previous-cycle sample of the pulse input.
  always_ff @(posedge clk) begin
    if (rst) pulse_q <= 1'b0;
    else     pulse_q <= pulse_i;
  end

  assign rise_o = pulse_i & ~pulse_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Pulse period meter: times the spacing between rising edges of a pulse
// train and reports sum/min/max over each window of WIN_PULSES intervals.
// Windows are back-to-back: the edge closing one window opens the next.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter  int WIN_PULSES = 10,
  parameter  int CNT_W      = 16,
  parameter  int TIMEOUT    = 1000,
  localparam int SUM_W      = CNT_W + clog2(WIN_PULSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  output logic             result_valid,
  output logic [SUM_W-1:0] period_sum,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             timeout
);

  localparam int WC_W = (clog2(WIN_PULSES + 1) < 1) ? 1 : clog2(WIN_PULSES + 1);

  logic             rise;
  logic [0:0]       state_q,   state_d;
  logic [CNT_W-1:0] icnt_q,    icnt_d;
  logic [WC_W-1:0]  win_q,     win_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0] acc_min_q, acc_min_d;
  logic [CNT_W-1:0] acc_max_q, acc_max_d;
  logic [SUM_W-1:0] sum_q,     sum_d;
  logic [CNT_W-1:0] min_q,     min_d;
  logic [CNT_W-1:0] max_q,     max_d;
  logic             rv_q,      rv_d;
  logic             to_q,      to_d;

  // Accumulators with the current interval folded in.
  logic [SUM_W-1:0] new_sum;
  logic [CNT_W-1:0] new_min;
  logic [CNT_W-1:0] new_max;

  pulse_period_meter_rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .pulse_i(pulse_in),
    .rise_o (rise)
  );

  // Fold the running interval into the window statistics.
  always_comb begin
    new_sum = acc_sum_q + SUM_W'(icnt_q);
    new_min = (icnt_q < acc_min_q) ? icnt_q : acc_min_q;
    new_max = (icnt_q > acc_max_q) ? icnt_q : acc_max_q;
  end

  // Measurement FSM: arm on first edge, capture intervals, publish or abort.
  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    win_d     = win_q;
    acc_sum_d = acc_sum_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    rv_d      = 1'b0;
    to_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      // First edge only starts timing; no interval exists yet.
      if (en && rise) begin
        state_d   = ST_MEASURE;
        icnt_d    = CNT_W'(1);
        win_d     = '0;
        acc_sum_d = '0;
        acc_min_d = '1;
        acc_max_d = '0;
      end
    end else begin
      if (!en) begin
        // Disable discards the partial window silently.
        state_d = ST_IDLE;
      end else if (rise) begin
        // An edge arriving on the timeout cycle still counts as an interval.
        icnt_d = CNT_W'(1);
        if (win_q == WC_W'(WIN_PULSES - 1)) begin
          sum_d     = new_sum;
          min_d     = new_min;
          max_d     = new_max;
          rv_d      = 1'b1;
          win_d     = '0;
          acc_sum_d = '0;
          acc_min_d = '1;
          acc_max_d = '0;
        end else begin
          win_d     = win_q + WC_W'(1);
          acc_sum_d = new_sum;
          acc_min_d = new_min;
          acc_max_d = new_max;
        end
      end else if (icnt_q == CNT_W'(TIMEOUT)) begin
        to_d    = 1'b1;
        state_d = ST_IDLE;
      end else begin
        icnt_d = icnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset clears everything including results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      icnt_q    <= '0;
      win_q     <= '0;
      acc_sum_q <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      rv_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      icnt_q    <= icnt_d;
      win_q     <= win_d;
      acc_sum_q <= acc_sum_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      rv_q      <= rv_d;
      to_q      <= to_d;
    end
  end

  assign result_valid = rv_q;
  assign period_sum   = sum_q;
  assign period_min   = min_q;
  assign period_max   = max_q;
  assign timeout      = to_q;

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Measures the clk-cycle spacing of a pulse train such as the output of the team's fractional/integer clock dividers. Detects rising edges of a clk-synchronous pulse input, times each interval, and reports sum/min/max over a window of WIN_PULSES intervals. Used as the checking end for divider outputs in self-test and frequency-monitoring paths.

Parameters:
WIN_PULSES, 10, intervals per measurement window (>=1)
CNT_W, 16, interval counter width in bits
TIMEOUT, 1000, cycles without a rising edge before the measurement aborts (2 <= TIMEOUT < 2**CNT_W)
SUM_W, CNT_W+$clog2(WIN_PULSES+1), derived width of the sum output (localparam, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  measurement enable; low forces IDLE and discards the partial window
pulse_in  input  1  pulse train, synchronous to clk
result_valid  output  1  one-cycle strobe: window complete, result outputs updated
period_sum  output  SUM_W  total cycles across the last complete window
period_min  output  CNT_W  shortest interval in the last window
period_max  output  CNT_W  longest interval in the last window
timeout  output  1  one-cycle strobe: TIMEOUT cycles passed with no edge while measuring

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0, state IDLE, edge register 0, counters 0.
- Edge detect: rise = pulse_in & ~pulse_q; pulse_q registers pulse_in every cycle, including in IDLE.
- States: IDLE, MEASURE.
- IDLE: on rise with en=1 -> MEASURE; icnt<=1, win_cnt<=0, acc_sum<=0, acc_min<=all-ones, acc_max<=0. No interval is captured on this first edge.
- MEASURE, no rise: icnt<=icnt+1.
- MEASURE, rise: interval=icnt; acc_sum+=interval; acc_min/acc_max updated with interval; win_cnt+=1; icnt<=1.
- Window complete: the rise that makes win_cnt reach WIN_PULSES registers period_sum/min/max from the accumulators including that interval, and result_valid=1 on the next cycle only. The same rise starts the next window (accumulators cleared, win_cnt=0, icnt=1); windows are back-to-back and the edge is never lost.
- Interval definition: cycles between consecutive rises. A pulse every N cycles gives interval N. Pulses wider than one cycle count once at their rising edge.
- Timeout: in MEASURE, when icnt==TIMEOUT and no rise occurs that cycle, timeout=1 for one cycle, the partial window is discarded, and state returns to IDLE. Result outputs keep their previous values.
- A rise in the same cycle as icnt==TIMEOUT wins: the interval is captured and no timeout is raised.
- en=0: state goes to IDLE next cycle and the partial window is discarded. Result outputs are held, and no result_valid or timeout is raised.
- Widths: icnt never exceeds TIMEOUT, so no saturation logic is needed. SUM_W holds WIN_PULSES*TIMEOUT without overflow.
- result_valid and timeout are mutually exclusive and never back-to-back from the same window.
- rst mid-window: same effect as power-on reset, and all outputs clear to 0.

Decomposition:
- Shared package/header: state encoding (IDLE=1'b0, MEASURE=1'b1) and the clog2 helper function, shared with the divider family.
- Optional sub-module: rise_detect (pulse_q register plus AND). Everything else stays in pulse_period_meter.

Test Plan:
- WIN_PULSES=4; pulse every 5 cycles; en=1 -> first result_valid 20 cycles after the first edge (+1 cycle); sum=20, min=5, max=5; repeats every 20 cycles.
- WIN_PULSES=10; nine intervals of 5 then one of 8 -> sum=53, min=5, max=8; next window starts on the same edge, with no gap in valid strobes.
- TIMEOUT=50; two edges, then silence -> timeout strobe exactly 50 cycles after the last edge; result outputs unchanged; the next edge re-arms IDLE->MEASURE without a result.
- Rise exactly when icnt==TIMEOUT -> interval=TIMEOUT captured, timeout stays 0.
- Drop en for 1 cycle mid-window, then resume the 5-cycle train -> no stale result; the first result after re-arm contains only post-enable intervals (sum=20 for WIN_PULSES=4).
- Assert rst for 1 cycle mid-window -> all outputs 0 on the next cycle; measurement restarts on the next rise.
